qa_stream_fifo: RTL and testbench

Parametrised successor to the plain QA DUT wrapper: a buffered, paced sample stream stage placed between the myhdl test bench drive signals and the DUT under test. Samples arriving on the `in_nd` strobe are stored in a DEPTH-entry FIFO and re-emitted no more often than once every SPACING cycles. An overflow drops samples and raises a sticky error flag. This lets benches exercise DUTs that cannot accept back-to-back input, and detect lost samples instead of silently corrupting results.

---
 rtl/qa_stream_fifo_pkg.sv | 20 ++
 rtl/qa_stream_fifo_mem.sv | 48 ++++
 rtl/qa_stream_fifo.sv | 112 +++++++++++
 tb/tb_qa_stream_fifo.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qa_stream_fifo_pkg.sv
// Shared definitions for the QA stream FIFO.
// Holds default parameter values and the width helpers used by the FIFO top and
// its storage sub-module.
package qa_stream_fifo_pkg;

    localparam int unsigned DefaultWidth   = 32;
    localparam int unsigned DefaultDepth   = 16;
    localparam int unsigned DefaultSpacing = 1;

    // Occupancy needs one extra bit so that full (DEPTH) and empty (0) differ.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Pace counter only ever holds 0..spacing-1; keep at least one bit.
    function automatic int unsigned pace_width(input int unsigned spacing);
        return (spacing > 1) ? $clog2(spacing) : 1;
    endfunction

endpackage

// File: rtl/qa_stream_fifo_mem.sv
// DEPTH x WIDTH register array for the QA stream FIFO.
// Synchronous write; registered read whose output register holds its value
// between reads and clears on reset.
//   clk_i      : clock
//   rst_i      : asynchronous active-high reset (read register only)
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_en_i    : read strobe; loads rd_data_o from rd_addr_i
//   rd_addr_i  : read address
//   rd_data_o  : registered read data
module qa_stream_fifo_mem #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage has no reset: entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Reads see pre-edge contents, so a same-address write on the same edge
    // (full FIFO, simultaneous read/write) returns the old head entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/qa_stream_fifo.sv
// Buffered, paced sample stream stage.
// Samples strobed in on in_nd_i are queued in a DEPTH-entry FIFO and re-emitted
// no more often than once every SPACING cycles. A sample arriving while the
// FIFO is full (and not draining on the same edge) is dropped and sets a sticky
// error flag. All outputs are registered.
//   clk_i      : clock
//   reset_i    : asynchronous active-high reset
//   in_data_i  : input sample, valid with in_nd_i
//   in_nd_i    : input new-data strobe
//   out_data_o : output sample, valid with out_nd_o
//   out_nd_o   : output new-data strobe, one cycle per sample
//   count_o    : FIFO occupancy 0..DEPTH
//   error_o    : sticky overflow flag
module qa_stream_fifo
    import qa_stream_fifo_pkg::*;
#(
    parameter int unsigned WIDTH   = DefaultWidth,
    parameter int unsigned DEPTH   = DefaultDepth,
    parameter int unsigned SPACING = DefaultSpacing
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [WIDTH-1:0]            in_data_i,
    input  logic                        in_nd_i,
    output logic [WIDTH-1:0]            out_data_o,
    output logic                        out_nd_o,
    output logic [cnt_width(DEPTH)-1:0] count_o,
    output logic                        error_o
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned CntW  = cnt_width(DEPTH);
    localparam int unsigned PaceW = pace_width(SPACING);

    localparam logic [CntW-1:0]  CntFull  = CntW'(DEPTH);
    localparam logic [PaceW-1:0] PaceLoad = PaceW'(SPACING - 1);

    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [PaceW-1:0] pace_q, pace_d;
    logic             error_q, error_d;
    logic             out_nd_q, out_nd_d;

    logic rd_en;
    logic wr_en;
    logic overflow;

    always_comb begin
        rd_en    = (count_q != '0) && (pace_q == '0);
        // A full FIFO still accepts a write when it frees a slot on the same edge.
        wr_en    = in_nd_i && ((count_q != CntFull) || rd_en);
        overflow = in_nd_i && !wr_en;

        wr_ptr_d = wr_en ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + AddrW'(1) : rd_ptr_q;

        count_d = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        pace_d = pace_q;
        if (rd_en) begin
            pace_d = PaceLoad;
        end else if (pace_q != '0) begin
            pace_d = pace_q - PaceW'(1);
        end

        error_d  = error_q | overflow;
        out_nd_d = rd_en;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pace_q   <= '0;
            error_q  <= 1'b0;
            out_nd_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pace_q   <= pace_d;
            error_q  <= error_d;
            out_nd_q <= out_nd_d;
        end
    end

    qa_stream_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i     (clk_i),
        .rst_i     (reset_i),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_data_i),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (out_data_o)
    );

    assign out_nd_o = out_nd_q;
    assign count_o  = count_q;
    assign error_o  = error_q;

endmodule

// File: tb/tb_qa_stream_fifo.sv
// Self-checking bench for qa_stream_fifo.
// Four instances with different DEPTH/SPACING share clock and reset; only one
// lane is stimulated at a time, so a single expected-data queue serves all.
//   lane 0: DEPTH=16 SPACING=1   lane 1: DEPTH=16 SPACING=4
//   lane 2: DEPTH=4  SPACING=8   lane 3: DEPTH=4  SPACING=1
module tb_qa_stream_fifo;

    logic        clk;
    logic        reset;
    logic [31:0] in_data [4];
    logic        in_nd   [4];
    logic [31:0] out_data[4];
    logic        out_nd  [4];
    logic        error   [4];
    logic [4:0]  cnt     [4];
    logic [4:0]  c0, c1;
    logic [2:0]  c2, c3;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    int          cyc   = 0;

    logic [31:0] exp_q[$];
    int          out_cyc[$];
    int unsigned cnt_max[4];

    qa_stream_fifo #(.WIDTH(32), .DEPTH(16), .SPACING(1)) u_dut0 (
        .clk_i(clk), .reset_i(reset), .in_data_i(in_data[0]), .in_nd_i(in_nd[0]),
        .out_data_o(out_data[0]), .out_nd_o(out_nd[0]), .count_o(c0), .error_o(error[0])
    );
    qa_stream_fifo #(.WIDTH(32), .DEPTH(16), .SPACING(4)) u_dut1 (
        .clk_i(clk), .reset_i(reset), .in_data_i(in_data[1]), .in_nd_i(in_nd[1]),
        .out_data_o(out_data[1]), .out_nd_o(out_nd[1]), .count_o(c1), .error_o(error[1])
    );
    qa_stream_fifo #(.WIDTH(32), .DEPTH(4), .SPACING(8)) u_dut2 (
        .clk_i(clk), .reset_i(reset), .in_data_i(in_data[2]), .in_nd_i(in_nd[2]),
        .out_data_o(out_data[2]), .out_nd_o(out_nd[2]), .count_o(c2), .error_o(error[2])
    );
    qa_stream_fifo #(.WIDTH(32), .DEPTH(4), .SPACING(1)) u_dut3 (
        .clk_i(clk), .reset_i(reset), .in_data_i(in_data[3]), .in_nd_i(in_nd[3]),
        .out_data_o(out_data[3]), .out_nd_o(out_nd[3]), .count_o(c3), .error_o(error[3])
    );

    assign cnt[0] = c0;
    assign cnt[1] = c1;
    assign cnt[2] = {2'b00, c2};
    assign cnt[3] = {2'b00, c3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on every out_nd pulse.
    always @(negedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (32'(cnt[l]) > cnt_max[l]) cnt_max[l] = 32'(cnt[l]);
            if (reset && out_nd[l]) check($sformatf("nd_in_reset%0d", l), 32'(out_nd[l]), 32'd0);
            if (out_nd[l]) begin
                out_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check($sformatf("extra_out%0d", l), 32'(exp_q.size()), 32'd1);
                end else begin
                    check($sformatf("data%0d", l), out_data[l], exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input int l, input logic [31:0] d, input bit push);
        in_data[l] = d;
        in_nd[l]   = 1'b1;
        if (push) exp_q.push_back(d);
        @(posedge clk);
        #1;
        in_nd[l] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        idle(4);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic start_test(input int l);
        out_cyc.delete();
        cnt_max[l] = 0;
    endtask

    task automatic check_gaps(input string tag, input int n, input int gap);
        check({tag, "_n"}, 32'(out_cyc.size()), 32'(n));
        if (out_cyc.size() == n) begin
            for (int i = 1; i < n; i++) begin
                check({tag, "_gap"}, 32'(out_cyc[i] - out_cyc[i-1]), 32'(gap));
            end
        end
    endtask

    initial begin
        int t0;
        reset = 1'b1;
        for (int l = 0; l < 4; l++) begin
            in_data[l] = '0;
            in_nd[l]   = 1'b0;
            cnt_max[l] = 0;
        end
        @(posedge clk);
        #1;
        for (int l = 0; l < 4; l++) begin
            check($sformatf("rst_nd%0d", l), 32'(out_nd[l]), 32'd0);
            check($sformatf("rst_data%0d", l), out_data[l], 32'd0);
            check($sformatf("rst_cnt%0d", l), 32'(cnt[l]), 32'd0);
            check($sformatf("rst_err%0d", l), 32'(error[l]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Pass-through: in_nd sampled on edge e gives out_nd after edge e+1.
        start_test(0);
        t0 = cyc;
        for (int i = 1; i <= 8; i++) send(0, 32'(i), 1'b1);
        wait_drain(40);
        check_gaps("pt", 8, 1);
        if (out_cyc.size() > 0) check("pt_lat", 32'(out_cyc[0]), 32'(t0 + 2));
        check("pt_cnt_max", 32'(cnt_max[0]), 32'd1);
        check("pt_err", 32'(error[0]), 32'd0);

        // Pacing at SPACING=4.
        start_test(1);
        for (int i = 0; i < 4; i++) send(1, 32'hA0 + 32'(i), 1'b1);
        wait_drain(60);
        check_gaps("pace", 4, 4);
        check("pace_cnt_max", 32'(cnt_max[1]), 32'd3);
        check("pace_err", 32'(error[1]), 32'd0);

        // Overflow: DEPTH=4, SPACING=8, six back-to-back samples; 5 is dropped.
        start_test(2);
        for (int i = 0; i < 5; i++) send(2, 32'(i), 1'b1);
        check("ovf_err_before", 32'(error[2]), 32'd0);
        send(2, 32'd5, 1'b0);
        check("ovf_err_rise", 32'(error[2]), 32'd1);
        check("ovf_cnt_full", 32'(cnt[2]), 32'd4);
        wait_drain(120);
        check_gaps("ovf", 5, 8);
        check("ovf_err_sticky", 32'(error[2]), 32'd1);
        check("ovf_cnt_empty", 32'(cnt[2]), 32'd0);

        pulse_reset();
        check("rst_clears_err", 32'(error[2]), 32'd0);

        // Full with simultaneous read: reads fall on edges t0+2, t0+10, t0+18, ...
        start_test(2);
        t0 = cyc;
        for (int i = 0; i < 5; i++) send(2, 32'h10 + 32'(i), 1'b1);
        check("full_cnt", 32'(cnt[2]), 32'd4);
        for (int k = 0; k < 3; k++) begin
            while (cyc < t0 + 9 + 8 * k) idle(1);
            send(2, 32'h15 + 32'(k), 1'b1);
            check("full_rw_cnt", 32'(cnt[2]), 32'd4);
            check("full_rw_err", 32'(error[2]), 32'd0);
        end
        wait_drain(120);
        check("full_cnt_max", 32'(cnt_max[2]), 32'd4);
        check("full_err_end", 32'(error[2]), 32'd0);

        // Pointer wrap on DEPTH=4 with occasional input gaps.
        start_test(3);
        for (int i = 0; i < 20; i++) begin
            if (i % 6 == 5) idle(1);
            send(3, 32'h100 + 32'(i), 1'b1);
        end
        wait_drain(60);
        check("wrap_n", 32'(out_cyc.size()), 32'd20);
        check("wrap_err", 32'(error[3]), 32'd0);

        // Mid-stream reset with three samples queued.
        start_test(1);
        send(1, 32'h31, 1'b1);
        for (int i = 2; i <= 4; i++) send(1, 32'h30 + 32'(i), 1'b0);
        check("mrst_pre_cnt", 32'(cnt[1]), 32'd3);
        check("mrst_pre_data", out_data[1], 32'h31);
        #2;
        reset = 1'b1;
        #1;
        check("mrst_nd", 32'(out_nd[1]), 32'd0);
        check("mrst_data", out_data[1], 32'd0);
        check("mrst_cnt", 32'(cnt[1]), 32'd0);
        check("mrst_err", 32'(error[1]), 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        out_cyc.delete();
        t0 = cyc;
        send(1, 32'h55, 1'b1);
        wait_drain(40);
        check("mrst_n", 32'(out_cyc.size()), 32'd1);
        if (out_cyc.size() > 0) check("mrst_lat", 32'(out_cyc[0]), 32'(t0 + 2));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "timeout");
    end

endmodule
